// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled up/down counter: overflow mode encodings and default widths.
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 24;
    localparam int unsigned PRE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10
    } cnt_mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler issuing one step every limit+1 enabled cycles.
// Only built when COUNTER_PRESCALER_EN is defined.
`ifdef COUNTER_PRESCALER_EN
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRE_WIDTH = PRE_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] limit,
    output logic                 step
);

    logic [PRE_WIDTH-1:0] pre;

    // >= so that lowering limit below the running count steps at once instead of wrapping
    assign step = en && (pre >= limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
        end else if (en) begin
            if (step) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_WIDTH'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/prescaled_updown_counter.sv
// Up/down counter with selectable wrap/saturate/one-shot overflow, parallel load and terminal-count pulse.
// Prescaler present only when COUNTER_PRESCALER_EN is defined; otherwise every enabled cycle steps.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = CNT_WIDTH_DEF,
    parameter int unsigned PRE_WIDTH = PRE_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [PRE_WIDTH-1:0] limit,
    output logic [WIDTH-1:0]     ctr,
    output logic                 tick,
    output logic                 tc,
    output logic                 done
);

    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] ctr_d;
    logic             tick_d;
    logic             tc_d;
    logic             done_d;

`ifdef COUNTER_PRESCALER_EN
    tick_prescaler #(
        .PRE_WIDTH(PRE_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .limit(limit),
        .step (step)
    );
`else
    logic unused_limit;
    assign unused_limit = ^limit;
    assign step         = en;
`endif

    always_comb begin
        ctr_d    = ctr;
        tick_d   = 1'b0;
        tc_d     = 1'b0;
        done_d   = done;
        at_bound = up_dn ? (ctr == '1) : (ctr == '0);
        if (load) begin
            ctr_d  = load_val;
            done_d = 1'b0;
        end else if (step && !done) begin
            tick_d = 1'b1;
            if (at_bound) begin
                tc_d = 1'b1;
                case (mode)
                    CNT_SAT:     ctr_d  = ctr;
                    CNT_ONESHOT: done_d = 1'b1;
                    default:     ctr_d  = up_dn ? '0 : '1;
                endcase
            end else begin
                ctr_d = up_dn ? ctr + WIDTH'(1) : ctr - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            ctr  <= ctr_d;
            tick <= tick_d;
            tc   <= tc_d;
            done <= done_d;
        end
    end

endmodule

// File: doc/prescaled_updown_counter.md
# prescaled_updown_counter

Parametrised up/down counter with a run-time programmable prescaler, selectable overflow behaviour, parallel load and terminal-count signalling. It is the general counter block for user designs on the board. It sits behind the `io_in`/`io_out` pad mapping in `top`: `rst` comes from `io_in[0]`, and `ctr`/status drive `io_out` for LED or logic-analyser observation.

## Interface
Parameters:
- `WIDTH`, 24: counter width, 2..32.
- `PRE_WIDTH`, 16: prescaler width, 1..24.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; gates prescaler and counter.
- `up_dn`  in  1: direction; 1 = up, 0 = down; sampled on each step.
- `mode`  in  2: overflow mode; 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- `load`  in  1: parallel load strobe.
- `load_val`  in  WIDTH: value loaded into `ctr`.
- `limit`  in  PRE_WIDTH: prescaler terminal value; step period is `limit`+1 enabled cycles.
- `ctr`  out  WIDTH: counter value, registered.
- `tick`  out  1: registered pulse, high for the cycle after each step edge.
- `tc`  out  1: registered pulse for a step attempted at the boundary.
- `done`  out  1: one-shot expired flag, sticky.

## Operation
- Priority per edge: `rst` > `load` > step > hold.
- Reset: `ctr`=0, prescale=0, `tick`=0, `tc`=0, `done`=0.
- Load:
  - `ctr`=`load_val` and prescale=0.
  - `done`=0; `tick` and `tc` are 0 next cycle.
  - `en` is ignored in that cycle.
- Prescaler (step condition):
  - When `en`=1 and prescale >= `limit`: prescale <= 0 and a step occurs.
  - Otherwise, when `en`=1: prescale increments.
  - When `en`=0: prescale holds.
  - The `>=` compare means lowering `limit` below the current prescale causes an immediate step, not a 2^PRE_WIDTH wrap.
  - `limit`=0: step on every enabled cycle.
- Step, normal case: `ctr` ± 1 per `up_dn`, modulo 2^WIDTH arithmetic.
- Step at boundary (`ctr`=2^WIDTH−1 and up, or `ctr`=0 and down):
  - wrap: `ctr` rolls over to 0 or to max.
  - saturate: `ctr` holds.
  - one-shot: `ctr` holds and `done` <= 1.
  - All modes: `tc` pulses.
- With `done`=1:
  - Steps leave `ctr` unchanged, and `tick` and `tc` stay 0.
  - The prescaler keeps running.
  - Only `load` or `rst` clears `done`.
- Changing `mode` or `up_dn` mid-count takes effect on the next step; no state is cleared.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- With `en` held high from the reset release, the first step edge is the (`limit`+1)-th rising edge. `ctr` changes at that edge and `tick` is high in the following cycle, aligned with the new `ctr`.
- `tc` coincides with `tick` on boundary steps.
- `load` is visible on `ctr` one cycle after the strobe.
- `rst` asserted mid-count clears everything at the next edge regardless of `load`/`en`.

## Configuration
- `COUNTER_PRESCALER_EN` defined:
  - The prescaler is built as described.
- `COUNTER_PRESCALER_EN` undefined:
  - The prescaler register is removed and `limit` is ignored but kept as a port.
  - Every cycle with `en`=1 is a step. All other behaviour is identical.
  - Equivalent to `limit`=0.

## Structure
- Package `counter_pkg` holds:
  - mode encodings `CNT_WRAP`, `CNT_SAT`, `CNT_ONESHOT`;
  - the `cnt_mode_t` typedef;
  - default widths `CNT_WIDTH_DEF`=24 and `PRE_WIDTH_DEF`=16.
- One sub-module, `tick_prescaler`:
  - inputs: `clk`, `rst`, `en`, `clr`, `limit`;
  - output: `step`, combinational from its register and `en`;
  - wrapped entirely in the `COUNTER_PRESCALER_EN` conditional.
- The top level holds the counter, the mode logic and the output registers.

## Test plan
- Reset then `en`=1, `up_dn`=1, `limit`=3, wrap → `ctr` goes 1,2,3 at edges 4,8,12; `tick` is high one cycle after each.
- WIDTH=4, `load_val`=14, up, wrap, `limit`=0 → `ctr` goes 15,0,1; `tc` is high only in the cycle after the 15→0 step.
- Saturate, down, `load_val`=1, `limit`=0 → `ctr` goes 0,0,0; `tc` pulses on each blocked step.
- One-shot, up, WIDTH=4, `load_val`=15 → first step sets `done`=1 with `ctr`=15; later steps give no `tick`; `load` of 5 clears `done`.
- `limit`=100, prescale at 50, then `limit` changes to 10 → step on the next enabled edge; afterwards the period is 11 cycles.
- `rst` and `load` asserted together mid-count → all outputs 0 next cycle. A build with the macro undefined and `limit`=100 → `ctr` increments every enabled cycle.
